// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for the MIPS-subset datapath: steps each instruction through
// fetch/decode/execute/memory/write-back and issues one control word per cycle.
//
// state  | meaning
// FETCH  | read instruction over the shared memory port, load IR and PC+4 on ack
// DECODE | latch instruction class from opcode, dispatch
// EXEC   | ALU operation for R-type, addi, lw/sw address
// MEM    | data access for lw/sw over the shared memory port
// WB     | register-file write for R-type, addi, lw
// BRANCH | beq compare, PC load from branch target when zero
// JUMP   | PC load from jump target
// HALT   | all enables off until reset
module multicycle_control (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        alu_src_b,
  output logic [3:0]  alu_op,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic [2:0]  state,
  output logic        halted,
  output logic [31:0] instr_count
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_BRANCH = 3'd5,
    S_JUMP   = 3'd6,
    S_HALT   = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    C_NONE  = 3'd0,
    C_RTYPE = 3'd1,
    C_ADDI  = 3'd2,
    C_LW    = 3'd3,
    C_SW    = 3'd4
  } cls_e;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SLT = 4'd4;

  state_e      state_q, state_d;
  cls_e        cls_q, cls_d;
  logic [31:0] count_q, count_d;
  logic        retire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      cls_q   <= C_NONE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    retire     = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    alu_src_b  = 1'b0;
    alu_op     = ALU_ADD;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    halted     = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        // Reset gating keeps an ack that arrives during reset from loading IR/PC.
        ir_write = mem_ack & ~rst;
        pc_write = mem_ack & ~rst;
        if (mem_ack) state_d = S_DECODE;
      end
      S_DECODE: begin
        unique case (opcode)
          6'b000000: begin cls_d = C_RTYPE; state_d = S_EXEC;   end
          6'b001000: begin cls_d = C_ADDI;  state_d = S_EXEC;   end
          6'b100011: begin cls_d = C_LW;    state_d = S_EXEC;   end
          6'b101011: begin cls_d = C_SW;    state_d = S_EXEC;   end
          6'b000100: begin cls_d = C_NONE;  state_d = S_BRANCH; end
          6'b000010: begin cls_d = C_NONE;  state_d = S_JUMP;   end
          6'b111111: begin cls_d = C_NONE;  state_d = S_HALT;   end
          default: begin
            cls_d   = C_NONE;
            state_d = S_FETCH;
            retire  = 1'b1;
          end
        endcase
      end
      S_EXEC: begin
        if (cls_q == C_RTYPE) begin
          unique case (funct)
            6'b100010: alu_op = ALU_SUB;
            6'b100100: alu_op = ALU_AND;
            6'b100101: alu_op = ALU_OR;
            6'b101010: alu_op = ALU_SLT;
            default:   alu_op = ALU_ADD;
          endcase
          state_d = S_WB;
        end else begin
          alu_src_b = 1'b1;
          state_d   = (cls_q == C_ADDI) ? S_WB : S_MEM;
        end
      end
      S_MEM: begin
        mem_req   = 1'b1;
        iord      = 1'b1;
        mem_we    = (cls_q == C_SW);
        alu_src_b = 1'b1;
        if (mem_ack) begin
          if (cls_q == C_SW) begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (cls_q == C_RTYPE);
        mem_to_reg = (cls_q == C_LW);
        state_d    = S_FETCH;
        retire     = 1'b1;
      end
      S_BRANCH: begin
        alu_op   = ALU_SUB;
        pc_src   = 2'b01;
        pc_write = zero & ~rst;
        state_d  = S_FETCH;
        retire   = 1'b1;
      end
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = ~rst;
        state_d  = S_FETCH;
        retire   = 1'b1;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    count_d = count_q + {31'd0, retire};
  end

  assign state       = state_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle vector table plus hand-written
// sequences for halt, reset during a memory access, and counter wrap.
module tb_multicycle_control;

  logic        clk, rst;
  logic [5:0]  opcode, funct;
  logic        zero, mem_ack;
  logic        mem_req, mem_we, iord, ir_write, pc_write;
  logic [1:0]  pc_src;
  logic        alu_src_b;
  logic [3:0]  alu_op;
  logic        reg_write, reg_dst, mem_to_reg;
  logic [2:0]  state;
  logic        halted;
  logic [31:0] instr_count;

  int n_cmp = 0;
  int n_bad = 0;

  multicycle_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .state(state),
    .halted(halted), .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_first;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic        ack;
    logic [2:0]  st;
    logic [15:0] cw;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[$];

  localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_LW = 6'b100011,
                         OP_SW = 6'b101011, OP_BEQ = 6'b000100, OP_J = 6'b000010,
                         OP_HALT = 6'b111111, OP_UNK = 6'b010101;

  // Control word: {req, we, iord, irw, pcw, pc_src[1:0], srcb, alu_op[3:0], rw, rdst, m2r, halted}
  function automatic logic [15:0] cw(input logic req, we, io, irw, pcw, input logic [1:0] pcs,
                                     input logic srcb, input logic [3:0] aop,
                                     input logic rw, rd, m2r, h);
    return {req, we, io, irw, pcw, pcs, srcb, aop, rw, rd, m2r, h};
  endfunction

  function automatic logic [15:0] act_cw();
    return {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_b, alu_op,
            reg_write, reg_dst, mem_to_reg, halted};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [5:0] op, input logic [5:0] fn, input logic z,
                     input logic ack, input logic [2:0] st, input logic [15:0] w,
                     input logic [31:0] cnt);
    vec_t v;
    v.rst_first = r; v.op = op; v.fn = fn; v.z = z; v.ack = ack;
    v.st = st; v.cw = w; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  logic [15:0] CW_FETCH_ACK, CW_FETCH_WAIT, CW_IDLE;

  task automatic rtype(input logic [5:0] fn, input logic [3:0] aop, input logic [31:0] c);
    add(0, OP_R, fn, 0, 1, 3'd0, CW_FETCH_ACK, c);
    add(0, OP_R, fn, 0, 1, 3'd1, CW_IDLE, c);
    add(0, OP_R, fn, 0, 1, 3'd2, cw(0,0,0,0,0,2'b00,0,aop,0,0,0,0), c);
    add(0, OP_R, fn, 0, 1, 3'd4, cw(0,0,0,0,0,2'b00,0,4'd0,1,1,0,0), c);
  endtask

  initial begin
    CW_FETCH_ACK  = cw(1,0,0,1,1,2'b00,0,4'd0,0,0,0,0);
    CW_FETCH_WAIT = cw(1,0,0,0,0,2'b00,0,4'd0,0,0,0,0);
    CW_IDLE       = 16'h0000;

    rtype(6'b100000, 4'd0, 0);
    rtype(6'b100010, 4'd1, 1);
    rtype(6'b100100, 4'd2, 2);
    rtype(6'b100101, 4'd3, 3);
    rtype(6'b101010, 4'd4, 4);
    rtype(6'b111111, 4'd0, 5);
    // addi
    add(0, OP_ADDI, 0, 0, 1, 3'd0, CW_FETCH_ACK, 6);
    add(0, OP_ADDI, 0, 0, 1, 3'd1, CW_IDLE, 6);
    add(0, OP_ADDI, 0, 0, 1, 3'd2, cw(0,0,0,0,0,2'b00,1,4'd0,0,0,0,0), 6);
    add(0, OP_ADDI, 0, 0, 1, 3'd4, cw(0,0,0,0,0,2'b00,0,4'd0,1,0,0,0), 6);
    // lw with two wait cycles in MEM
    add(0, OP_LW, 0, 0, 1, 3'd0, CW_FETCH_ACK, 7);
    add(0, OP_LW, 0, 0, 1, 3'd1, CW_IDLE, 7);
    add(0, OP_LW, 0, 0, 1, 3'd2, cw(0,0,0,0,0,2'b00,1,4'd0,0,0,0,0), 7);
    add(0, OP_LW, 0, 0, 0, 3'd3, cw(1,0,1,0,0,2'b00,1,4'd0,0,0,0,0), 7);
    add(0, OP_LW, 0, 0, 0, 3'd3, cw(1,0,1,0,0,2'b00,1,4'd0,0,0,0,0), 7);
    add(0, OP_LW, 0, 0, 1, 3'd3, cw(1,0,1,0,0,2'b00,1,4'd0,0,0,0,0), 7);
    add(0, OP_LW, 0, 0, 1, 3'd4, cw(0,0,0,0,0,2'b00,0,4'd0,1,0,1,0), 7);
    // beq taken, with one fetch wait cycle
    add(0, OP_BEQ, 0, 1, 0, 3'd0, CW_FETCH_WAIT, 8);
    add(0, OP_BEQ, 0, 1, 1, 3'd0, CW_FETCH_ACK, 8);
    add(0, OP_BEQ, 0, 1, 1, 3'd1, CW_IDLE, 8);
    add(0, OP_BEQ, 0, 1, 1, 3'd5, cw(0,0,0,0,1,2'b01,0,4'd1,0,0,0,0), 8);
    // beq not taken
    add(0, OP_BEQ, 0, 0, 1, 3'd0, CW_FETCH_ACK, 9);
    add(0, OP_BEQ, 0, 0, 1, 3'd1, CW_IDLE, 9);
    add(0, OP_BEQ, 0, 0, 1, 3'd5, cw(0,0,0,0,0,2'b01,0,4'd1,0,0,0,0), 9);
    // reset, then sw, j, unknown, halt
    add(1, OP_SW, 0, 0, 1, 3'd0, CW_FETCH_ACK, 0);
    add(0, OP_SW, 0, 0, 1, 3'd1, CW_IDLE, 0);
    add(0, OP_SW, 0, 0, 1, 3'd2, cw(0,0,0,0,0,2'b00,1,4'd0,0,0,0,0), 0);
    add(0, OP_SW, 0, 0, 1, 3'd3, cw(1,1,1,0,0,2'b00,1,4'd0,0,0,0,0), 0);
    add(0, OP_J, 0, 0, 1, 3'd0, CW_FETCH_ACK, 1);
    add(0, OP_J, 0, 0, 1, 3'd1, CW_IDLE, 1);
    add(0, OP_J, 0, 0, 1, 3'd6, cw(0,0,0,0,1,2'b10,0,4'd0,0,0,0,0), 1);
    add(0, OP_UNK, 0, 0, 1, 3'd0, CW_FETCH_ACK, 2);
    add(0, OP_UNK, 0, 0, 1, 3'd1, CW_IDLE, 2);
    add(0, OP_HALT, 0, 0, 1, 3'd0, CW_FETCH_ACK, 3);
    add(0, OP_HALT, 0, 0, 1, 3'd1, CW_IDLE, 3);
    add(0, OP_HALT, 0, 0, 1, 3'd7, cw(0,0,0,0,0,2'b00,0,4'd0,0,0,0,1), 3);

    // Reset state, with an ack present that must not load IR/PC
    rst = 1'b1; opcode = OP_R; funct = 6'd0; zero = 1'b0; mem_ack = 1'b1;
    @(negedge clk); #1;
    chk("reset state", {29'd0, state}, 32'd0);
    chk("reset count", instr_count, 32'd0);
    chk("reset cw", {16'd0, act_cw()}, {16'd0, CW_FETCH_WAIT});
    mem_ack = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      if (vecs[i].rst_first) begin
        rst = 1'b1; #1; rst = 1'b0;
      end
      opcode = vecs[i].op; funct = vecs[i].fn; zero = vecs[i].z; mem_ack = vecs[i].ack;
      #1;
      chk($sformatf("row%0d state", i), {29'd0, state}, {29'd0, vecs[i].st});
      chk($sformatf("row%0d cw", i), {16'd0, act_cw()}, {16'd0, vecs[i].cw});
      chk($sformatf("row%0d count", i), instr_count, vecs[i].cnt);
    end

    // HALT holds for 20 cycles, ignoring mem_ack
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      chk($sformatf("halt%0d state", k), {29'd0, state}, 32'd7);
      chk($sformatf("halt%0d count", k), instr_count, 32'd3);
    end
    chk("halt flag", {31'd0, halted}, 32'd1);

    // Reset in the middle of an sw memory access with ack withheld
    @(negedge clk);
    rst = 1'b1; opcode = OP_J; mem_ack = 1'b1; #1; rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("j retire state", {29'd0, state}, 32'd0);
    chk("j retire count", instr_count, 32'd1);
    opcode = OP_SW;
    repeat (3) @(negedge clk);
    mem_ack = 1'b0; #1;
    chk("sw mem state", {29'd0, state}, 32'd3);
    chk("sw mem_we", {31'd0, mem_we}, 32'd1);
    @(negedge clk);
    chk("sw mem held", {29'd0, state}, 32'd3);
    rst = 1'b1; mem_ack = 1'b1; #1;
    chk("rst mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst state", {29'd0, state}, 32'd0);
    chk("rst count", instr_count, 32'd0);
    chk("rst writes", {30'd0, ir_write, pc_write}, 32'd0);
    chk("rst reg_write", {31'd0, reg_write}, 32'd0);
    mem_ack = 1'b0; rst = 1'b0; #1;
    chk("post-rst mem_req", {31'd0, mem_req}, 32'd1);
    chk("post-rst state", {29'd0, state}, 32'd0);

    // Counter wrap on retirement of a j
    @(negedge clk);
    opcode = OP_J; mem_ack = 1'b1;
    force dut.count_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.count_q;
    #1;
    chk("wrap preload", instr_count, 32'hFFFF_FFFF);
    chk("wrap decode", {29'd0, state}, 32'd1);
    @(negedge clk); #1;
    chk("wrap jump", {29'd0, state}, 32'd6);
    @(negedge clk); #1;
    chk("wrap count", instr_count, 32'd0);
    chk("wrap fetch", {29'd0, state}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
